lwc_pdo_sink: RTL and testbench

- Downstream consumer of the LWC core's do_* output bus. Accepts do_data/do_valid/do_last under a valid/ready handshake.
- Parses output segment headers and the final status word.
- Emits a byte-qualified payload stream plus per-message status to the host/bench side.
- Sits between LWC.do_* and the result-comparison logic of the top-level wrapper and all benches.

---
 rtl/lwc_pdo_sink_pkg.sv | 26 ++
 rtl/lwc_pdo_sink_keep_gen.sv | 23 ++
 rtl/lwc_pdo_sink.sv | 144 ++++++++++++++
 tb/tb_lwc_pdo_sink.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwc_pdo_sink_pkg.sv
// Shared constants for the LWC do_* output sink: bus defaults, status codes,
// segment type codes, header field offsets and the FSM state encoding.
package lwc_pdo_sink_pkg;

  localparam int         PKG_BUSW      = 32;
  localparam int         PKG_LENW      = 16;
  localparam logic [3:0] PKG_STAT_OK   = 4'hE;
  localparam logic [3:0] PKG_STAT_FAIL = 4'hF;

  localparam logic [3:0] SEG_AD     = 4'h1;
  localparam logic [3:0] SEG_PLAIN  = 4'h4;
  localparam logic [3:0] SEG_CIPHER = 4'h5;
  localparam logic [3:0] SEG_TAG    = 4'h8;
  localparam logic [3:0] SEG_NPUB   = 4'hD;

  // Byte positions inside a header word, counted from byte0 at the MSB end
  localparam int HDR_TYPE_BYTE = 0;
  localparam int HDR_LEN_BYTE  = 2;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_STAT = 2'd2
  } state_t;

endpackage

// File: rtl/lwc_pdo_sink_keep_gen.sv
// Byte count of the next payload word (min of remaining bytes and bus bytes)
// and the matching MSB-aligned byte-keep mask.
module pdo_keep_gen #(
  parameter int BUSW = 32,
  parameter int LENW = 16
) (
  input  logic [LENW-1:0]   rem,
  output logic [LENW-1:0]   n_bytes,
  output logic [BUSW/8-1:0] keep
);

  localparam int              BPW   = BUSW / 8;
  localparam logic [LENW-1:0] BPW_L = LENW'(BPW);

  always_comb begin
    n_bytes = (rem < BPW_L) ? rem : BPW_L;
    keep    = '0;
    for (int i = 0; i < BPW; i++) begin
      keep[BPW-1-i] = (LENW'(i) < n_bytes);
    end
  end

endmodule

// File: rtl/lwc_pdo_sink.sv
// Consumer of the LWC do_* bus: parses segment headers, forwards payload with
// byte keeps and reports message status. Optional checks: PDO_PROTOCOL_CHECK_EN.
module lwc_pdo_sink
  import lwc_pdo_sink_pkg::*;
#(
  parameter int         BUSW      = PKG_BUSW,
  parameter logic [3:0] STAT_OK   = PKG_STAT_OK,
  parameter logic [3:0] STAT_FAIL = PKG_STAT_FAIL,
  parameter int         LENW      = PKG_LENW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUSW-1:0]   do_data,
  input  logic              do_valid,
  input  logic              do_last,
  output logic              do_ready,
  output logic [BUSW-1:0]   pld_data,
  output logic [BUSW/8-1:0] pld_keep,
  output logic [3:0]        pld_type,
  output logic              pld_last,
  output logic              pld_valid,
  input  logic              pld_ready,
  output logic              msg_done,
  output logic              msg_ok,
  output logic              proto_err
);

  localparam int              BPW      = BUSW / 8;
  localparam logic [LENW-1:0] BPW_L    = LENW'(BPW);
  localparam int              TYPE_MSB = BUSW - 1 - 8 * HDR_TYPE_BYTE;
  localparam int              LEN_MSB  = BUSW - 1 - 8 * HDR_LEN_BYTE;

  state_t            state, state_nxt;
  logic [LENW-1:0]   rem, rem_nxt;
  logic [3:0]        seg_type, seg_type_nxt;
  logic              last_seg, last_seg_nxt;
  logic [LENW-1:0]   n_bytes;
  logic [BPW-1:0]    keep;
  logic              accept, word_err, load_pld, stat_fire, err;
  logic [3:0]        byte0_hi;
  logic              hdr_last;
  logic [LENW-1:0]   hdr_len;

  assign byte0_hi = do_data[TYPE_MSB -: 4];
  assign hdr_last = do_data[TYPE_MSB - 7];
  assign hdr_len  = LENW'(do_data[LEN_MSB -: 16]);

  assign do_ready = (state != S_DATA) || !pld_valid || pld_ready;
  assign accept   = do_valid && do_ready;

`ifdef PDO_PROTOCOL_CHECK_EN
  // Only the status word may carry do_last, and it must carry a known nibble
  assign word_err = (state == S_STAT)
                  ? (!do_last || ((byte0_hi != STAT_OK) && (byte0_hi != STAT_FAIL)))
                  : do_last;
`else
  logic unused_proto;
  assign word_err     = 1'b0;
  assign unused_proto = &{1'b0, do_last, STAT_FAIL};
`endif

  pdo_keep_gen #(
    .BUSW (BUSW),
    .LENW (LENW)
  ) u_keep_gen (
    .rem     (rem),
    .n_bytes (n_bytes),
    .keep    (keep)
  );

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    seg_type_nxt = seg_type;
    last_seg_nxt = last_seg;
    load_pld     = 1'b0;
    stat_fire    = 1'b0;
    err          = 1'b0;
    if (accept) begin
      if (word_err) begin
        err       = 1'b1;
        state_nxt = S_HDR;
        rem_nxt   = '0;
      end else begin
        case (state)
          S_HDR: begin
            seg_type_nxt = byte0_hi;
            last_seg_nxt = hdr_last;
            rem_nxt      = hdr_len;
            if (hdr_len != '0) state_nxt = S_DATA;
            else if (hdr_last) state_nxt = S_STAT;
            else               state_nxt = S_HDR;
          end
          S_DATA: begin
            load_pld = 1'b1;
            rem_nxt  = rem - n_bytes;
            if (rem <= BPW_L) state_nxt = last_seg ? S_STAT : S_HDR;
          end
          S_STAT: begin
            stat_fire = 1'b1;
            state_nxt = S_HDR;
          end
          default: state_nxt = S_HDR;
        endcase
      end
    end
  end

  // The payload register frees itself on pld_ready unless refilled in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_HDR;
      rem       <= '0;
      seg_type  <= '0;
      last_seg  <= 1'b0;
      pld_valid <= 1'b0;
      pld_data  <= '0;
      pld_keep  <= '0;
      pld_type  <= '0;
      pld_last  <= 1'b0;
      msg_done  <= 1'b0;
      msg_ok    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      seg_type  <= seg_type_nxt;
      last_seg  <= last_seg_nxt;
      msg_done  <= stat_fire;
      proto_err <= err;
      if (stat_fire) msg_ok <= (byte0_hi == STAT_OK);
      if (load_pld) begin
        pld_valid <= 1'b1;
        pld_data  <= do_data;
        pld_keep  <= keep;
        pld_type  <= seg_type;
        pld_last  <= (rem <= BPW_L);
      end else if (pld_ready) begin
        pld_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lwc_pdo_sink.sv
// Randomised bench for lwc_pdo_sink: a message-level model builds the expected
// payload/status streams, and one negedge process checks the DUT each cycle.
module tb_lwc_pdo_sink;
  import lwc_pdo_sink_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] do_data = '0;
  logic        do_valid = 1'b0;
  logic        do_last = 1'b0;
  logic        do_ready;
  logic [31:0] pld_data;
  logic [3:0]  pld_keep;
  logic [3:0]  pld_type;
  logic        pld_last;
  logic        pld_valid;
  logic        pld_ready = 1'b1;
  logic        msg_done;
  logic        msg_ok;
  logic        proto_err;

  always #5 clk = ~clk;

  lwc_pdo_sink dut (
    .clk       (clk),
    .rst       (rst),
    .do_data   (do_data),
    .do_valid  (do_valid),
    .do_last   (do_last),
    .do_ready  (do_ready),
    .pld_data  (pld_data),
    .pld_keep  (pld_keep),
    .pld_type  (pld_type),
    .pld_last  (pld_last),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .msg_done  (msg_done),
    .msg_ok    (msg_ok),
    .proto_err (proto_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        isData;
    logic        isStat;
    logic        bad;
  } word_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  ptype;
    logic        plast;
  } pld_t;

  word_t txQ[$];
  pld_t  expPld[$];
  logic  expStat[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   pldCount = 0;
  logic [3:0] lastKeep = '0;
  logic checkEn = 1'b0;
  logic curIsData = 1'b0, curIsStat = 1'b0, curBad = 1'b0;
  logic randReady = 1'b0;
  int   cycle = 0;
  int   holdUntil = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keep mask for a word when 'left' payload bytes remain in the segment
  function automatic logic [3:0] keepFor(input int left);
    int n;
    n = (left < 4) ? left : 4;
    return 4'(((1 << n) - 1) << (4 - n));
  endfunction

  task automatic addSegment(input logic [3:0] t, input logic [3:0] flags, input int len,
                            input logic lastOnFirstData);
    word_t w;
    pld_t  p;
    int    left;
    w.data = {t, flags, 8'h00, 16'(len)};
    w.last = 1'b0; w.isData = 1'b0; w.isStat = 1'b0; w.bad = 1'b0;
    txQ.push_back(w);
    left = len;
    for (int i = 0; left > 0; i++) begin
      w.data = $urandom; w.isData = 1'b1; w.last = 1'b0; w.bad = 1'b0;
      if (lastOnFirstData && i == 0) begin
        w.last = 1'b1;
`ifdef PDO_PROTOCOL_CHECK_EN
        w.bad = 1'b1;
`endif
      end
      txQ.push_back(w);
      if (!w.bad) begin
        p.data = w.data; p.keep = keepFor(left); p.ptype = t; p.plast = (left <= 4);
        expPld.push_back(p);
      end
      left -= 4;
    end
  endtask

  task automatic addStatus(input logic [3:0] nib);
    word_t w;
    w.data = {nib, 28'($urandom)};
    w.last = 1'b1; w.isData = 1'b0; w.isStat = 1'b1; w.bad = 1'b0;
    txQ.push_back(w);
    expStat.push_back(nib == 4'hE);
  endtask

  task automatic waitAccept();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = do_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("accept_timeout", {63'd0, ok}, 64'd1);
  endtask

  // Sends up to nWords queued words (all if negative); stalls pld_ready at index stallAt
  task automatic applyStimulus(input int nWords, input int stallAt, input bit gaps);
    word_t w;
    int    sent;
    sent = 0;
    while (txQ.size() > 0 && (nWords < 0 || sent < nWords)) begin
      w = txQ.pop_front();
      if (gaps) begin
        do_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      do_data = w.data; do_last = w.last;
      curIsData = w.isData; curIsStat = w.isStat; curBad = w.bad;
      do_valid = 1'b1;
      if (sent == stallAt) holdUntil = cycle + 6;
      waitAccept();
      sent++;
    end
    do_valid = 1'b0;
    do_last  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 500 && (expPld.size() > 0 || expStat.size() > 0); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain_payload", 64'(expPld.size()), 64'd0);
    checkOutput("drain_status", 64'(expStat.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    cycle = cycle + 1;
    if (cycle < holdUntil)  pld_ready = 1'b0;
    else if (randReady)     pld_ready = 1'($urandom_range(0, 1));
    else                    pld_ready = 1'b1;
  end

  logic        justData = 1'b0, justStat = 1'b0, prevHold = 1'b0, expProto = 1'b0;
  logic        accepted;
  logic [31:0] lastData = '0;
  logic [40:0] heldVec = '0;
  pld_t        e;

  always @(negedge clk) begin
    if (!checkEn) begin
      justData = 1'b0; justStat = 1'b0; prevHold = 1'b0; expProto = 1'b0;
    end else begin
      if (justData) checkOutput("latency_data", {pld_valid, pld_data}, {1'b1, lastData});
      if (prevHold)
        checkOutput("hold_stable", {pld_valid, pld_data, pld_keep, pld_type, pld_last}, {1'b1, heldVec});
      checkOutput("msg_done", {63'd0, msg_done}, {63'd0, justStat});
      if (msg_done) begin
        if (expStat.size() == 0) checkOutput("status_extra", 64'(expStat.size()), 64'd1);
        else checkOutput("msg_ok", {63'd0, msg_ok}, {63'd0, expStat.pop_front()});
      end
      checkOutput("proto_err", {63'd0, proto_err}, {63'd0, expProto});
      if (pld_valid && pld_ready) begin
        if (expPld.size() == 0) checkOutput("payload_extra", 64'(expPld.size()), 64'd1);
        else begin
          e = expPld.pop_front();
          checkOutput("payload", {pld_data, pld_keep, pld_type, pld_last},
                      {e.data, e.keep, e.ptype, e.plast});
        end
        pldCount = pldCount + 1;
        lastKeep = pld_keep;
      end
      prevHold = pld_valid && !pld_ready;
      heldVec  = {pld_data, pld_keep, pld_type, pld_last};
      if (do_valid)
        checkOutput("do_ready", {63'd0, do_ready},
                    {63'd0, curIsData ? !(pld_valid && !pld_ready) : 1'b1});
      accepted = do_valid && do_ready;
      justData = accepted && curIsData && !curBad;
      justStat = accepted && curIsStat && !curBad;
      expProto = accepted && curBad;
      lastData = do_data;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_outputs"},
                {pld_valid, pld_data, pld_keep, pld_type, pld_last, msg_done, msg_ok, proto_err},
                64'd0);
  endtask

  int base;
  logic [3:0] segTypes [5];

  initial begin
    segTypes = '{SEG_AD, SEG_PLAIN, SEG_CIPHER, SEG_TAG, SEG_NPUB};
    $display("[TB] start");
    #1;
    checkResetOutputs("reset");
    checkOutput("model_keep_full", 64'(keepFor(16)), 64'hF);
    checkOutput("model_keep_3", 64'(keepFor(3)), 64'hE);
    checkOutput("model_keep_1", 64'(keepFor(1)), 64'h8);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("do_ready_after_reset", {63'd0, do_ready}, 64'd1);
    checkEn = 1'b1;

    // Two full segments followed by a success status
    base = pldCount;
    addSegment(SEG_CIPHER, 4'h2, 16, 1'b0);
    addSegment(SEG_TAG, 4'h3, 16, 1'b0);
    addStatus(4'hE);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
    checkOutput("t1_word_count", 64'(pldCount - base), 64'd8);
    checkOutput("t1_msg_ok", {63'd0, msg_ok}, 64'd1);

    // Seven-byte segment ending in a partial word, failure status
    addSegment(SEG_PLAIN, 4'h1, 7, 1'b0);
    addStatus(4'hF);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
    checkOutput("t2_last_keep", 64'(lastKeep), 64'hE);
    checkOutput("t2_msg_ok", {63'd0, msg_ok}, 64'd0);

    // Zero-length final segment produces no payload
    base = pldCount;
    addSegment(SEG_AD, 4'h1, 0, 1'b0);
    addStatus(4'hE);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
    checkOutput("t3_no_payload", 64'(pldCount - base), 64'd0);
    checkOutput("t3_msg_ok", {63'd0, msg_ok}, 64'd1);

    // Downstream stall in the middle of a segment
    base = pldCount;
    addSegment(SEG_PLAIN, 4'h1, 24, 1'b0);
    addStatus(4'hE);
    applyStimulus(-1, 3, 1'b0);
    waitDrain();
    checkOutput("t4_word_count", 64'(pldCount - base), 64'd6);

    // Asynchronous reset while the third data word is offered
    addSegment(SEG_PLAIN, 4'h1, 16, 1'b0);
    addStatus(4'hE);
    applyStimulus(3, -1, 1'b0);
    begin
      word_t w;
      w = txQ.pop_front();
      do_data = w.data; do_last = w.last; curIsData = w.isData; curIsStat = w.isStat;
      curBad = w.bad; do_valid = 1'b1;
    end
    checkEn = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkResetOutputs("midmsg_reset");
    do_valid = 1'b0;
    txQ.delete(); expPld.delete(); expStat.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("do_ready_after_midmsg_reset", {63'd0, do_ready}, 64'd1);
    checkEn = 1'b1;
    base = pldCount;
    addSegment(SEG_TAG, 4'h1, 8, 1'b0);
    addStatus(4'hE);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
    checkOutput("t5_word_count", 64'(pldCount - base), 64'd2);
    checkOutput("t5_msg_ok", {63'd0, msg_ok}, 64'd1);

    // do_last raised on a data word
`ifdef PDO_PROTOCOL_CHECK_EN
    addSegment(SEG_CIPHER, 4'h1, 4, 1'b1);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
    addSegment(SEG_TAG, 4'h1, 4, 1'b0);
    addStatus(4'hE);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
`else
    addSegment(SEG_CIPHER, 4'h1, 8, 1'b1);
    addStatus(4'hE);
    applyStimulus(-1, -1, 1'b0);
    waitDrain();
`endif

    // Random messages with idle gaps and random downstream back-pressure
    randReady = 1'b1;
    for (int m = 0; m < 25; m++) begin
      int nseg;
      nseg = $urandom_range(1, 3);
      for (int s = 0; s < nseg; s++) begin
        addSegment(segTypes[$urandom_range(0, 4)], {3'($urandom), 1'(s == nseg - 1)},
                   $urandom_range(0, 40), 1'b0);
      end
      addStatus($urandom_range(0, 1) ? 4'hE : 4'hF);
      applyStimulus(-1, -1, 1'b1);
    end
    waitDrain();
    randReady = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
